// File: rtl/time_of_day_counter.sv
// time_of_day_counter: HH:MM:SS time-of-day counter advanced by an internal
// prescaler, with synchronous time load, 12/24-hour display mapping, a day-wrap
// pulse and an hh:mm alarm. All outputs are registered.
module time_of_day_counter #(
  parameter int TICK_DIV = 1000,
  parameter int PS_W     = 10
) (
  input  logic            Clk,
  input  logic            reset_n,
  input  logic            run,
  input  logic            set_en,
  input  logic [4:0]      set_hh,
  input  logic [5:0]      set_mm,
  input  logic [5:0]      set_ss,
  input  logic            mode_12h,
  input  logic            alarm_en,
  input  logic [4:0]      alarm_hh,
  input  logic [5:0]      alarm_mm,
  output logic [5:0]      seconds,
  output logic [5:0]      minutes,
  output logic [4:0]      hours,
  output logic            pm,
  output logic            sec_pulse,
  output logic            day_wrap,
  output logic            alarm_hit,
  output logic            set_err
);

  localparam logic [PS_W-1:0] PS_LAST = PS_W'(TICK_DIV - 1);

  logic [4:0]      hh24, hh24_next;
  logic [5:0]      mm, mm_next;
  logic [5:0]      ss, ss_next;
  logic [PS_W-1:0] ps, ps_next;
  logic            set_ok, load, reject, tick, wrap_next, alarm_next;
  logic [4:0]      hours_next;

  // A set is honoured only when every field is in range; a valid set pre-empts the tick.
  assign set_ok = (set_hh <= 5'd23) && (set_mm <= 6'd59) && (set_ss <= 6'd59);
  assign load   = set_en && set_ok;
  assign reject = set_en && !set_ok;
  assign tick   = run && (ps == PS_LAST) && !load;

  // Next-state time: load, carry-chained advance on a tick, or hold.
  always_comb begin
    hh24_next = hh24;
    mm_next   = mm;
    ss_next   = ss;
    ps_next   = ps;
    wrap_next = 1'b0;
    if (load) begin
      hh24_next = set_hh;
      mm_next   = set_mm;
      ss_next   = set_ss;
      ps_next   = '0;
    end else if (run) begin
      if (ps == PS_LAST) begin
        ps_next = '0;
        if (ss == 6'd59) begin
          ss_next = 6'd0;
          if (mm == 6'd59) begin
            mm_next = 6'd0;
            if (hh24 == 5'd23) begin
              hh24_next = 5'd0;
              wrap_next = 1'b1;
            end else begin
              hh24_next = hh24 + 5'd1;
            end
          end else begin
            mm_next = mm + 6'd1;
          end
        end else begin
          ss_next = ss + 6'd1;
        end
      end else begin
        ps_next = ps + PS_W'(1);
      end
    end
  end

  // Alarm fires only on a tick landing on hh:mm:00; out-of-range alarm values never match.
  always_comb begin
    alarm_next = 1'b0;
    if (tick && alarm_en && (alarm_hh <= 5'd23) && (alarm_mm <= 6'd59) &&
        (hh24_next == alarm_hh) && (mm_next == alarm_mm) && (ss_next == 6'd0))
      alarm_next = 1'b1;
  end

  // Display hour mapping from the upcoming internal hour and the current mode.
  always_comb begin
    hours_next = hh24_next;
    if (mode_12h) begin
      if (hh24_next == 5'd0)
        hours_next = 5'd12;
      else if (hh24_next > 5'd12)
        hours_next = hh24_next - 5'd12;
    end
  end

  // Internal time, prescaler and all registered outputs.
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      hh24      <= 5'd0;
      mm        <= 6'd0;
      ss        <= 6'd0;
      ps        <= '0;
      seconds   <= 6'd0;
      minutes   <= 6'd0;
      hours     <= mode_12h ? 5'd12 : 5'd0;
      pm        <= 1'b0;
      sec_pulse <= 1'b0;
      day_wrap  <= 1'b0;
      alarm_hit <= 1'b0;
      set_err   <= 1'b0;
    end else begin
      hh24      <= hh24_next;
      mm        <= mm_next;
      ss        <= ss_next;
      ps        <= ps_next;
      seconds   <= ss_next;
      minutes   <= mm_next;
      hours     <= hours_next;
      pm        <= (hh24_next >= 5'd12);
      sec_pulse <= tick;
      day_wrap  <= tick && wrap_next;
      alarm_hit <= alarm_next;
      set_err   <= reject;
    end
  end

endmodule

// File: tb/tb_time_of_day_counter.sv
// tb_time_of_day_counter: directed checks of the time-of-day counter with a
// 4-cycle second, expected values worked out by hand for each scenario.
module tb_time_of_day_counter;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       run;
  logic       set_en;
  logic [4:0] set_hh;
  logic [5:0] set_mm;
  logic [5:0] set_ss;
  logic       mode_12h;
  logic       alarm_en;
  logic [4:0] alarm_hh;
  logic [5:0] alarm_mm;
  logic [5:0] seconds;
  logic [5:0] minutes;
  logic [4:0] hours;
  logic       pm;
  logic       sec_pulse;
  logic       day_wrap;
  logic       alarm_hit;
  logic       set_err;

  int checks = 0;
  int errors = 0;
  int cycles;
  logic seen;

  time_of_day_counter #(.TICK_DIV(4), .PS_W(3)) dut (
    .Clk(clk), .reset_n(reset_n), .run(run), .set_en(set_en),
    .set_hh(set_hh), .set_mm(set_mm), .set_ss(set_ss), .mode_12h(mode_12h),
    .alarm_en(alarm_en), .alarm_hh(alarm_hh), .alarm_mm(alarm_mm),
    .seconds(seconds), .minutes(minutes), .hours(hours), .pm(pm),
    .sec_pulse(sec_pulse), .day_wrap(day_wrap), .alarm_hit(alarm_hit),
    .set_err(set_err)
  );

  // Free-running 10-time-unit clock.
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    if (observed != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int hh, input int mm, input int ss);
    set_hh = 5'(hh);
    set_mm = 6'(mm);
    set_ss = 6'(ss);
    set_en = 1'b1;
    @(negedge clk);
    set_en = 1'b0;
  endtask

  task automatic waitSecPulse(output int count);
    count = 0;
    do begin
      @(negedge clk);
      count++;
    end while (!sec_pulse && count < 20);
    if (!sec_pulse) checkOutput("pulse_timeout", 0, 1);
  endtask

  task automatic checkTime(input string tag, input int hh, input int mm, input int ss);
    checkOutput({tag, "_hh"}, int'(hours), hh);
    checkOutput({tag, "_mm"}, int'(minutes), mm);
    checkOutput({tag, "_ss"}, int'(seconds), ss);
  endtask

  initial begin
    reset_n = 1'b0; run = 1'b1; set_en = 1'b0;
    set_hh = '0; set_mm = '0; set_ss = '0;
    mode_12h = 1'b0; alarm_en = 1'b0; alarm_hh = 5'd7; alarm_mm = 6'd30;

    // Reset state in both display modes
    repeat (2) @(negedge clk);
    checkTime("reset", 0, 0, 0);
    checkOutput("reset_pm", int'(pm), 0);
    checkOutput("reset_pulse", int'(sec_pulse), 0);
    mode_12h = 1'b1;
    @(negedge clk);
    checkOutput("reset_hours_12h", int'(hours), 12);
    mode_12h = 1'b0;
    @(negedge clk);
    checkOutput("reset_hours_24h", int'(hours), 0);

    // Free run: one second every 4 cycles, seconds roll into minutes
    reset_n = 1'b1;
    waitSecPulse(cycles);
    checkOutput("first_tick_cycles", cycles, 4);
    checkOutput("first_tick_ss", int'(seconds), 1);
    @(negedge clk);
    checkOutput("pulse_width", int'(sec_pulse), 0);
    waitSecPulse(cycles);
    checkOutput("second_tick_cycles", cycles, 3);
    checkOutput("second_tick_ss", int'(seconds), 2);
    for (int i = 3; i <= 60; i++) begin
      waitSecPulse(cycles);
      if (i < 60) checkOutput("run_ss", int'(seconds), i);
    end
    checkTime("minute_roll", 0, 1, 0);

    // Day wrap from 23:59:58
    applyStimulus(23, 59, 58);
    checkTime("set_2359", 23, 59, 58);
    waitSecPulse(cycles);
    checkOutput("pre_wrap_cycles", cycles, 4);
    checkOutput("pre_wrap_flag", int'(day_wrap), 0);
    waitSecPulse(cycles);
    checkTime("wrap", 0, 0, 0);
    checkOutput("wrap_flag", int'(day_wrap), 1);
    @(negedge clk);
    checkOutput("wrap_flag_clear", int'(day_wrap), 0);

    // 12-hour display mapping with time held
    run = 1'b0;
    mode_12h = 1'b1;
    applyStimulus(13, 5, 0);
    checkOutput("h13_12h", int'(hours), 1);
    checkOutput("h13_pm", int'(pm), 1);
    checkOutput("h13_mm", int'(minutes), 5);
    applyStimulus(0, 10, 0);
    checkOutput("h00_12h", int'(hours), 12);
    checkOutput("h00_pm", int'(pm), 0);
    mode_12h = 1'b0;
    @(negedge clk);
    checkOutput("h00_24h", int'(hours), 0);
    applyStimulus(12, 0, 0);
    checkOutput("h12_pm", int'(pm), 1);

    // Alarm at 07:30
    run = 1'b1;
    alarm_en = 1'b1;
    applyStimulus(7, 29, 59);
    waitSecPulse(cycles);
    checkTime("alarm_time", 7, 30, 0);
    checkOutput("alarm_hit", int'(alarm_hit), 1);
    waitSecPulse(cycles);
    checkOutput("alarm_once", int'(alarm_hit), 0);
    alarm_en = 1'b0;
    applyStimulus(7, 29, 59);
    waitSecPulse(cycles);
    checkOutput("alarm_disabled_mm", int'(minutes), 30);
    checkOutput("alarm_disabled", int'(alarm_hit), 0);
    alarm_en = 1'b1;
    applyStimulus(7, 30, 0);
    checkOutput("alarm_on_set", int'(alarm_hit), 0);

    // Rejected set and set coinciding with a tick
    run = 1'b0;
    applyStimulus(10, 20, 30);
    applyStimulus(1, 60, 0);
    checkOutput("set_err", int'(set_err), 1);
    checkTime("rejected", 10, 20, 30);
    @(negedge clk);
    checkOutput("set_err_clear", int'(set_err), 0);
    run = 1'b1;
    applyStimulus(5, 6, 7);
    repeat (3) @(negedge clk);
    applyStimulus(8, 9, 10);
    checkTime("set_vs_tick", 8, 9, 10);
    checkOutput("set_vs_tick_pulse", int'(sec_pulse), 0);
    waitSecPulse(cycles);
    checkOutput("after_set_cycles", cycles, 4);
    checkOutput("after_set_ss", int'(seconds), 11);

    // Hold mid-second, resume, then asynchronous reset mid-count
    applyStimulus(11, 22, 33);
    waitSecPulse(cycles);
    checkOutput("hold_start_ss", int'(seconds), 34);
    repeat (2) @(negedge clk);
    run = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      seen = seen | sec_pulse;
    end
    checkOutput("hold_no_pulse", int'(seen), 0);
    checkTime("hold", 11, 22, 34);
    run = 1'b1;
    waitSecPulse(cycles);
    checkOutput("resume_cycles", cycles, 2);
    checkOutput("resume_ss", int'(seconds), 35);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    checkTime("async_reset", 0, 0, 0);
    checkOutput("async_reset_pulse", int'(sec_pulse), 0);
    @(negedge clk);
    reset_n = 1'b1;
    waitSecPulse(cycles);
    checkOutput("post_reset_cycles", cycles, 4);
    checkOutput("post_reset_ss", int'(seconds), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
